// File: rtl/spi_tx_pkg.sv
// Shared types and default sizing for the SPI transmit scheduler and its serializer.
package spi_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        STOP  = 2'd3
    } spi_state_e;

    localparam int DATA_W_DEFAULT = 6;
    localparam int DIV_DEFAULT    = 1;

endpackage

// File: rtl/spi_tx_sched_if.sv
// Requester-side bus of the SPI transmit scheduler: two frame requesters plus serial pins.
interface spi_tx_sched_if #(
    parameter int DATA_W = spi_tx_pkg::DATA_W_DEFAULT
);
    // Handshake: the scheduler raises req_ready[i] for exactly one cycle while IDLE;
    // the word on req_data<i> is taken on the clock edge where req_valid[i] && req_ready[i].
    logic [1:0]             req_valid;
    logic [DATA_W-1:0]      req_data0;
    logic [DATA_W-1:0]      req_data1;
    logic [1:0]             req_ready;
    logic                   grant_id;
    logic                   busy;
    logic                   SCLK;
    logic                   CS;
    logic                   DO;
    spi_tx_pkg::spi_state_e state_dbg;

    modport master (
        output req_valid, req_data0, req_data1,
        input  req_ready, grant_id, busy, SCLK, CS, DO, state_dbg
    );

    modport slave (
        input  req_valid, req_data0, req_data1,
        output req_ready, grant_id, busy, SCLK, CS, DO, state_dbg
    );

endinterface

// File: rtl/spi_serializer.sv
// Shift register, bit counter, SCLK prescaler and DO for one SPI frame.
// Bit order: LSB-first by default, MSB-first when SPI_TX_SCHED_MSB_FIRST_EN is defined.
module spi_serializer
    import spi_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DIV    = DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  spi_state_e        state,
    output logic              setup_done,
    output logic              shift_done,
    output logic              sclk,
    output logic              sdo
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [CW-1:0] BITS      = CW'(DATA_W);

    logic [PW-1:0]     presc_q;
    logic [CW-1:0]     bit_cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_next;
    logic              sclk_q;
    logic              presc_end;
    logic              last_bit;
    logic              out_bit;

    assign presc_end = (presc_q == PRESC_MAX);
    assign last_bit  = (bit_cnt_q == BITS);

`ifdef SPI_TX_SCHED_MSB_FIRST_EN
    assign out_bit    = shreg_q[DATA_W-1];
    assign shreg_next = shreg_q << 1;
`else
    assign out_bit    = shreg_q[0];
    assign shreg_next = shreg_q >> 1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            sclk_q    <= 1'b0;
        end else if (load) begin
            presc_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= load_data;
            sclk_q    <= 1'b0;
        end else begin
            case (state)
                SETUP: begin
                    if (presc_end) begin
                        presc_q <= '0;
                        sclk_q  <= 1'b1;
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                SHIFT: begin
                    if (presc_end) begin
                        presc_q <= '0;
                        // A falling edge advances DO; after the last one SCLK stays low.
                        if (sclk_q) begin
                            sclk_q    <= 1'b0;
                            shreg_q   <= shreg_next;
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end else if (!last_bit) begin
                            sclk_q <= 1'b1;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                default: begin
                    presc_q <= '0;
                    sclk_q  <= 1'b0;
                end
            endcase
        end
    end

    assign setup_done = (state == SETUP) && presc_end;
    assign shift_done = (state == SHIFT) && presc_end && !sclk_q && last_bit;
    assign sclk       = sclk_q;
    assign sdo        = ((state == SETUP) || (state == SHIFT)) && out_bit;

endmodule

// File: rtl/spi_tx_sched.sv
// Two-requester round-robin SPI transmit scheduler: arbiter, frame FSM and chip select.
// Optional MSB-first bit order via SPI_TX_SCHED_MSB_FIRST_EN (handled in spi_serializer).
module spi_tx_sched
    import spi_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DIV    = DIV_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_tx_sched_if.slave  bus
);

    spi_state_e        state_q;
    spi_state_e        state_d;
    logic              rr_last_q;
    logic              grant_q;
    logic              win;
    logic              accept;
    logic              cs_n;
    logic              busy;
    logic [1:0]        ready;
    logic              setup_done;
    logic              shift_done;
    logic              sclk;
    logic              sdo;
    logic [DATA_W-1:0] load_data;

    // Tie goes to the requester not granted last; rst_n gating keeps ready low during reset.
    assign win       = (bus.req_valid == 2'b11) ? ~rr_last_q : bus.req_valid[1];
    assign accept    = (state_q == IDLE) && (|bus.req_valid) && rst_n;
    assign load_data = win ? bus.req_data1 : bus.req_data0;

    always_comb begin
        state_d = state_q;
        ready   = 2'b00;
        cs_n    = 1'b1;
        busy    = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    ready   = {win, ~win};
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cs_n = 1'b0;
                if (setup_done) state_d = SHIFT;
            end
            SHIFT: begin
                cs_n = 1'b0;
                if (shift_done) state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            grant_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rr_last_q <= win;
                grant_q   <= win;
            end
        end
    end

    spi_serializer #(
        .DATA_W (DATA_W),
        .DIV    (DIV)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .load_data  (load_data),
        .state      (state_q),
        .setup_done (setup_done),
        .shift_done (shift_done),
        .sclk       (sclk),
        .sdo        (sdo)
    );

    assign bus.req_ready = ready;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = busy;
    assign bus.CS        = cs_n;
    assign bus.SCLK      = sclk;
    assign bus.DO        = sdo;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_spi_tx_sched.sv
// Bench for spi_tx_sched: per-cycle timeline model of frames and arbitration, two DUTs (DIV=1, DIV=3).
module tb_spi_tx_sched;

    localparam int W     = 6;
    localparam int DIV_A = 1;
    localparam int DIV_B = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_tx_sched_if #(.DATA_W(W)) if_a ();
    spi_tx_sched_if #(.DATA_W(W)) if_b ();

    spi_tx_sched #(.DATA_W(W), .DIV(DIV_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    spi_tx_sched #(.DATA_W(W), .DIV(DIV_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame timeline position per DUT (-1 = idle), round-robin memory, grant.
    int           m_t[2];
    logic         m_last[2];
    logic         m_grant[2];
    logic         m_pend[2];
    logic [W-1:0] m_data[2];
    int           m_div[2];
    logic [W-1:0] exp_q[$];

    function automatic int bit_pos(int i);
`ifdef SPI_TX_SCHED_MSB_FIRST_EN
        return W - 1 - i;
`else
        return i;
`endif
    endfunction

    function automatic logic model_bit(logic [W-1:0] d, int i);
        return d[bit_pos(i)];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_t[k]     = -1;
            m_last[k]  = 1'b1;
            m_grant[k] = 1'b0;
            m_pend[k]  = 1'b0;
            m_data[k]  = '0;
        end
    endtask

    // Observation layout: {req_ready[1:0], grant_id, busy, CS, SCLK, DO}; mask clears don't-care DO.
    task automatic model_step(input int w, input logic [1:0] v, input logic [W-1:0] d0,
                              input logic [W-1:0] d1, output logic [6:0] e, output logic [6:0] m);
        int cur, dv, h, stop_t;
        logic win;
        logic [1:0] rdy;
        dv     = m_div[w];
        stop_t = 1 + dv + 2 * dv * W;
        rdy    = 2'b00;
        m      = 7'h7f;
        cur    = m_t[w];
        if (m_t[w] < 0 && v != 2'b00) begin
            win        = (v == 2'b11) ? ~m_last[w] : v[1];
            rdy        = win ? 2'b10 : 2'b01;
            m_data[w]  = win ? d1 : d0;
            m_last[w]  = win;
            m_pend[w]  = win;
            cur        = 0;
            if (w == 0) exp_q.push_back(m_data[w]);
        end
        if (cur == 1) m_grant[w] = m_pend[w];
        if (cur <= 0) begin
            e = {rdy, m_grant[w], 1'b0, 1'b1, 1'b0, 1'b0};
        end else if (cur <= dv) begin
            e = {2'b00, m_grant[w], 1'b1, 1'b0, 1'b0, model_bit(m_data[w], 0)};
        end else if (cur < stop_t) begin
            h = (cur - dv - 1) / dv;
            if (h % 2 == 0) e = {2'b00, m_grant[w], 1'b1, 1'b0, 1'b1, model_bit(m_data[w], h / 2)};
            else begin
                e    = {2'b00, m_grant[w], 1'b1, 1'b0, 1'b0, 1'b0};
                m[0] = 1'b0;
            end
        end else begin
            e = {2'b00, m_grant[w], 1'b1, 1'b1, 1'b0, 1'b0};
        end
        m_t[w] = (cur < 0 || cur == stop_t) ? -1 : cur + 1;
    endtask

    function automatic logic [6:0] sample(int w);
        if (w == 0) return {if_a.req_ready, if_a.grant_id, if_a.busy, if_a.CS, if_a.SCLK, if_a.DO};
        return {if_b.req_ready, if_b.grant_id, if_b.busy, if_b.CS, if_b.SCLK, if_b.DO};
    endfunction

    // Drive one cycle's inputs at the falling edge, then sample just after.
    task automatic tick(input int w, input logic [1:0] v, input logic [W-1:0] d0,
                        input logic [W-1:0] d1, output logic [6:0] obs);
        @(negedge clk);
        if (w == 0) begin
            if_a.req_valid = v; if_a.req_data0 = d0; if_a.req_data1 = d1;
            if_b.req_valid = 2'b00;
        end else begin
            if_b.req_valid = v; if_b.req_data0 = d0; if_b.req_data1 = d1;
            if_a.req_valid = 2'b00;
        end
        #1;
        obs = sample(w);
    endtask

    task automatic do_reset();
        @(negedge clk);
        if_a.req_valid = 2'b00;
        if_b.req_valid = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        if_a.req_valid = 2'b11; if_b.req_valid = 2'b11;
        if_a.req_data0 = '0; if_a.req_data1 = '0; if_b.req_data0 = '0; if_b.req_data1 = '0;
        #23;
        for (int w = 0; w < 2; w++) begin
            obs = sample(w);
            n_tests++;
            if (obs !== 7'b00_0_0_1_0_0) begin
                n_fail++;
                $display("FAIL reset_outputs dut=%0d got=%b exp=%b", w, obs, 7'b0000100);
            end
        end
        @(negedge clk);
        if_a.req_valid = 2'b00; if_b.req_valid = 2'b00;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        logic [6:0] obs, e, m;
        logic [1:0] v;
        logic [W-1:0] d, rx;
        logic [W-1:0] pats[2];
        int cs_low, nb;
        pats[0] = 6'b101101;
        pats[1] = 6'b100000;
        for (int f = 0; f < 2; f++) begin
            d = pats[f]; v = 2'b01; cs_low = 0; nb = 0; rx = '0;
            for (int c = 0; c < 16; c++) begin
                tick(0, v, d, 6'h00, obs);
                model_step(0, v, d, 6'h00, e, m);
                n_tests++;
                if ((obs & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL single_trace f=%0d cyc=%0d got=%b exp=%b", f, c, obs, e);
                end
                if (c == 1) begin
                    n_tests++;
                    if (obs[0] !== model_bit(d, 0)) begin
                        n_fail++;
                        $display("FAIL single_first_bit f=%0d got=%b exp=%b", f, obs[0], model_bit(d, 0));
                    end
                end
                if (obs[6:5] == 2'b01) v = 2'b00;
                if (obs[2] == 1'b0) cs_low++;
                if (obs[1] == 1'b1 && nb < W) begin
                    rx[bit_pos(nb)] = obs[0];
                    nb++;
                end
            end
            n_tests++;
            if (cs_low != 13) begin
                n_fail++;
                $display("FAIL single_cs_low f=%0d got=%0d exp=13", f, cs_low);
            end
            n_tests++;
            if (rx !== d) begin
                n_fail++;
                $display("FAIL single_word f=%0d got=%b exp=%b", f, rx, d);
            end
        end
    endtask

    task automatic test_tie();
        logic [6:0] obs, e, m;
        logic [1:0] v;
        int acc1;
        logic g1;
        do_reset();
        v = 2'b11; acc1 = -1; g1 = 1'b0;
        for (int c = 0; c < 32; c++) begin
            tick(0, v, 6'h15, 6'h2A, obs);
            model_step(0, v, 6'h15, 6'h2A, e, m);
            n_tests++;
            if ((obs & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL tie_trace cyc=%0d got=%b exp=%b", c, obs, e);
            end
            if (obs[6:5] == 2'b01) v[0] = 1'b0;
            if (obs[6:5] == 2'b10) begin
                v[1] = 1'b0;
                acc1 = c;
            end
            if (c == 16) g1 = obs[4];
        end
        n_tests++;
        if (acc1 != 15) begin
            n_fail++;
            $display("FAIL tie_second_accept got=%0d exp=15", acc1);
        end
        n_tests++;
        if (g1 !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_grant_id got=%b exp=1", g1);
        end
    endtask

    task automatic test_alternate();
        logic [6:0] obs, e, m;
        logic [W-1:0] d0, d1;
        int ng;
        logic seq[8];
        do_reset();
        ng = 0;
        for (int c = 0; c < 60; c++) begin
            d0 = W'($urandom); d1 = W'($urandom);
            tick(0, 2'b11, d0, d1, obs);
            model_step(0, 2'b11, d0, d1, e, m);
            n_tests++;
            if ((obs & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL alt_trace cyc=%0d got=%b exp=%b", c, obs, e);
            end
            if (obs[6:5] != 2'b00 && ng < 8) begin
                seq[ng] = obs[6];
                ng++;
            end
        end
        n_tests++;
        if (ng != 4) begin
            n_fail++;
            $display("FAIL alt_grant_count got=%0d exp=4", ng);
        end
        for (int k = 0; k < 4 && k < ng; k++) begin
            n_tests++;
            if (seq[k] !== k[0]) begin
                n_fail++;
                $display("FAIL alt_order k=%0d got=%b exp=%b", k, seq[k], k[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] obs, e, m;
        logic [1:0] v;
        logic [W-1:0] d0, d1, rx;
        logic prev_sclk, prev_cs;
        int nb;
        exp_q.delete();
        prev_sclk = 1'b0; prev_cs = 1'b1; nb = 0; rx = '0;
        for (int c = 0; c < 420; c++) begin
            v  = (c < 400) ? 2'($urandom_range(0, 3)) : 2'b00;
            d0 = W'($urandom); d1 = W'($urandom);
            tick(0, v, d0, d1, obs);
            model_step(0, v, d0, d1, e, m);
            n_tests++;
            if ((obs & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL rand_trace cyc=%0d v=%b got=%b exp=%b", c, v, obs, e);
            end
            if (prev_cs && !obs[2]) begin
                nb = 0; rx = '0;
            end
            if (obs[1] && !prev_sclk && nb < W) begin
                rx[bit_pos(nb)] = obs[0];
                nb++;
            end
            if (!prev_cs && obs[2]) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_word cyc=%0d got=%h exp=none", c, rx);
                end else if (rx !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rand_word cyc=%0d got=%h exp=%h", c, rx, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            prev_sclk = obs[1];
            prev_cs   = obs[2];
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [6:0] obs, e, m;
        logic [1:0] v;
        logic [W-1:0] d;
        int ab;
        logic saw_ready;
        for (int it = 0; it < 2; it++) begin
            ab = (it == 0) ? 7 : int'($urandom_range(2, 13));
            do_reset();
            v = 2'b01; d = W'($urandom);
            for (int c = 0; c <= ab; c++) begin
                tick(0, v, d, 6'h00, obs);
                model_step(0, v, d, 6'h00, e, m);
                n_tests++;
                if ((obs & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL abort_pre cyc=%0d got=%b exp=%b", c, obs, e);
                end
                if (obs[6:5] == 2'b01) v = 2'b00;
            end
            if_a.req_valid = 2'b11;
            rst_n = 1'b0;
            #1;
            obs = sample(0);
            n_tests++;
            if (obs !== 7'b00_0_0_1_0_0) begin
                n_fail++;
                $display("FAIL abort_async at=%0d got=%b exp=%b", ab, obs, 7'b0000100);
            end
            @(negedge clk);
            obs = sample(0);
            n_tests++;
            if (obs[1] !== 1'b0 || obs[6:5] !== 2'b00) begin
                n_fail++;
                $display("FAIL abort_held at=%0d got=%b exp=sclk 0 ready 00", ab, obs);
            end
            if_a.req_valid = 2'b00;
            rst_n = 1'b1;
            model_reset();
            v = 2'b11; d = W'($urandom); saw_ready = 1'b0;
            for (int c = 0; c < 16; c++) begin
                tick(0, v, d, ~d, obs);
                model_step(0, v, d, ~d, e, m);
                n_tests++;
                if ((obs & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL abort_post cyc=%0d got=%b exp=%b", c, obs, e);
                end
                if (c == 0) begin
                    n_tests++;
                    if (obs[6:5] !== 2'b01) begin
                        n_fail++;
                        $display("FAIL abort_first_win got=%b exp=01", obs[6:5]);
                    end
                end
                if (obs[6:5] != 2'b00) saw_ready = 1'b1;
                if (saw_ready) v = 2'b00;
            end
        end
    endtask

    task automatic test_div3();
        logic [6:0] obs, e, m;
        logic [1:0] v;
        logic [W-1:0] d;
        logic prev_sclk;
        int cs_low, r1, r2;
        do_reset();
        v = 2'b10; d = W'($urandom); cs_low = 0; r1 = -1; r2 = -1; prev_sclk = 1'b0;
        for (int c = 0; c < 44; c++) begin
            tick(1, v, 6'h00, d, obs);
            model_step(1, v, 6'h00, d, e, m);
            n_tests++;
            if ((obs & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL div3_trace cyc=%0d got=%b exp=%b", c, obs, e);
            end
            if (obs[6:5] == 2'b10) v = 2'b00;
            if (obs[2] == 1'b0) cs_low++;
            if (obs[1] && !prev_sclk) begin
                if (r1 < 0) r1 = c;
                else if (r2 < 0) r2 = c;
            end
            prev_sclk = obs[1];
        end
        n_tests++;
        if (cs_low != 39) begin
            n_fail++;
            $display("FAIL div3_cs_low got=%0d exp=39", cs_low);
        end
        n_tests++;
        if (r2 - r1 != 6) begin
            n_fail++;
            $display("FAIL div3_sclk_period got=%0d exp=6", r2 - r1);
        end
    endtask

    initial begin
        m_div[0] = DIV_A;
        m_div[1] = DIV_B;
        model_reset();
        test_reset();
        test_single();
        test_tie();
        test_alternate();
        test_random();
        test_mid_reset();
        test_div3();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
